// File: rtl/bp_be_dcache_lce_req_buffered.sv
// LCE request handler for the BE dcache. Cached and uncached-load misses go through an FSM.
// Uncached stores are posted through a credit-limited FIFO, so the cache can move on after a store.
module bp_be_dcache_lce_req_buffered
  #(parameter int paddr_width_p         = 40
  , parameter int dword_width_p         = 64
  , parameter int lce_id_width_p        = 4
  , parameter int cce_id_width_p        = 4
  , parameter int d_lce_assoc_p         = 8
  , parameter int uc_store_els_p        = 4
  , parameter int uc_credits_p          = 8
  , parameter int timeout_max_limit_p   = 4
  , localparam int way_width_lp         = $clog2(d_lce_assoc_p)
  , localparam int cache_req_width_lp   = 3 + 2 + paddr_width_p + dword_width_p
  , localparam int metadata_width_lp    = way_width_lp + 1
  , localparam int lce_cce_req_width_lp = cce_id_width_p + lce_id_width_p + 3 + 1 + 1
                                          + way_width_lp + 2 + paddr_width_p + dword_width_p
  , localparam int lce_cce_resp_width_lp = cce_id_width_p + lce_id_width_p + 3 + paddr_width_p
  )
  (input  logic                             clk_i
  , input  logic                            reset_i
  , input  logic [lce_id_width_p-1:0]       lce_id_i
  , input  logic [cache_req_width_lp-1:0]   cache_req_i
  , input  logic                            cache_req_v_i
  , output logic                            cache_req_ready_o
  , input  logic [metadata_width_lp-1:0]    cache_req_metadata_i
  , input  logic                            cache_req_metadata_v_i
  , output logic [paddr_width_p-1:0]        miss_addr_o
  , input  logic                            coherence_blocked_i
  , input  logic                            cmd_ready_i
  , input  logic                            cce_data_received_i
  , input  logic                            uncached_data_received_i
  , input  logic                            set_tag_received_i
  , input  logic                            set_tag_wakeup_received_i
  , input  logic                            uc_store_done_i
  , output logic                            fence_clear_o
  , output logic [lce_cce_req_width_lp-1:0] lce_req_o
  , output logic                            lce_req_v_o
  , input  logic                            lce_req_ready_i
  , output logic [lce_cce_resp_width_lp-1:0] lce_resp_o
  , output logic                            lce_resp_v_o
  , input  logic                            lce_resp_yumi_i
  );

  localparam logic [2:0] e_miss_load  = 3'd0;
  localparam logic [2:0] e_miss_store = 3'd1;
  localparam logic [2:0] e_uc_load    = 3'd2;
  localparam logic [2:0] e_uc_store   = 3'd3;
  localparam logic [2:0] e_req_rd     = 3'd0;
  localparam logic [2:0] e_req_wr     = 3'd1;
  localparam logic [2:0] e_req_uc_rd  = 3'd2;
  localparam logic [2:0] e_req_uc_wr  = 3'd3;
  localparam logic [2:0] e_resp_coh_ack = 3'd0;
  // CCE selection interleaves on 64-byte blocks
  localparam int block_offset_lp = 6;
  localparam int fifo_ptr_w_lp   = $clog2(uc_store_els_p);
  localparam int fifo_cnt_w_lp   = $clog2(uc_store_els_p + 1);
  localparam int credit_w_lp     = $clog2(uc_credits_p + 1);
  localparam int timeout_w_lp    = $clog2(timeout_max_limit_p + 1);
  localparam int fifo_entry_w_lp = paddr_width_p + 2 + dword_width_p;
  localparam logic [credit_w_lp-1:0]   credit_max_lp    = credit_w_lp'(uc_credits_p);
  localparam logic [timeout_w_lp-1:0]  timeout_limit_lp = timeout_w_lp'(timeout_max_limit_p);
  localparam logic [fifo_cnt_w_lp-1:0] fifo_depth_lp    = fifo_cnt_w_lp'(uc_store_els_p);

  typedef enum logic [2:0] {
    e_ready        = 3'd0,
    e_send_cached  = 3'd1,
    e_send_uc_load = 3'd2,
    e_sleep        = 3'd3,
    e_send_coh_ack = 3'd4
  } state_e;

  function automatic logic [fifo_ptr_w_lp-1:0] ptr_inc(input logic [fifo_ptr_w_lp-1:0] p);
    return (p == fifo_ptr_w_lp'(uc_store_els_p - 1)) ? '0 : p + fifo_ptr_w_lp'(1);
  endfunction

  state_e state_r, state_n;

  logic [2:0]               req_msg;
  logic [1:0]               req_size;
  logic [paddr_width_p-1:0] req_addr;
  logic [dword_width_p-1:0] req_data;
  logic [way_width_lp-1:0]  md_way;
  logic                     md_dirty;
  assign {req_msg, req_size, req_addr, req_data} = cache_req_i;
  assign {md_way, md_dirty} = cache_req_metadata_i;

  logic accept, is_miss, fifo_enq, fifo_deq, fifo_full, fifo_empty;
  logic uc_wr_xfer, miss_xfer, timeout, wake_any;
  assign accept   = cache_req_v_i & cache_req_ready_o;
  assign is_miss  = (req_msg == e_miss_load) | (req_msg == e_miss_store);
  assign fifo_enq = accept & (req_msg == e_uc_store);
  assign wake_any = cce_data_received_i | uncached_data_received_i
                  | set_tag_received_i | set_tag_wakeup_received_i;

  logic [paddr_width_p-1:0] miss_addr_r;
  logic                     load_not_store_r;
  logic [1:0]               uc_size_r;
  logic                     data_recv_r, tag_recv_r;
  logic                     md_v_r, md_dirty_r;
  logic [way_width_lp-1:0]  md_way_r;
  logic [credit_w_lp-1:0]   credits_r;
  logic [timeout_w_lp-1:0]  timeout_cnt_r;

  logic [fifo_entry_w_lp-1:0] fifo_mem [uc_store_els_p];
  logic [fifo_ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [fifo_cnt_w_lp-1:0]   fifo_cnt_r;
  logic [paddr_width_p-1:0]   head_addr;
  logic [1:0]                 head_size;
  logic [dword_width_p-1:0]   head_data;
  assign {head_addr, head_size, head_data} = fifo_mem[rd_ptr_r];
  assign fifo_full  = (fifo_cnt_r == fifo_depth_lp);
  assign fifo_empty = (fifo_cnt_r == '0);
  assign fifo_deq   = uc_wr_xfer;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: begin
        if (accept) begin
          case (req_msg)
            e_miss_load, e_miss_store: state_n = e_send_cached;
            e_uc_load:                 state_n = e_send_uc_load;
            default:                   state_n = e_ready;
          endcase
        end
      end
      e_send_cached, e_send_uc_load: if (miss_xfer) state_n = e_sleep;
      e_sleep: begin
        if (set_tag_wakeup_received_i)    state_n = e_send_coh_ack;
        else if (uncached_data_received_i) state_n = e_ready;
        else if ((tag_recv_r | set_tag_received_i) & (data_recv_r | cce_data_received_i))
          state_n = e_send_coh_ack;
      end
      e_send_coh_ack: if (lce_resp_yumi_i) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  // Output logic; the FIFO head always wins so no load can overtake an older store
  logic [2:0]               out_msg;
  logic                     out_dirty;
  logic [way_width_lp-1:0]  out_way;
  logic [1:0]               out_size;
  logic [paddr_width_p-1:0] out_addr;
  logic [dword_width_p-1:0] out_data;
  always_comb begin
    lce_req_v_o = 1'b0;
    out_msg     = e_req_uc_wr;
    out_dirty   = 1'b0;
    out_way     = '0;
    out_size    = head_size;
    out_addr    = head_addr;
    out_data    = head_data;
    if (!fifo_empty) begin
      lce_req_v_o = (credits_r != '0);
    end else if (state_r == e_send_cached) begin
      lce_req_v_o = md_v_r;
      out_msg     = load_not_store_r ? e_req_rd : e_req_wr;
      out_dirty   = md_dirty_r;
      out_way     = md_way_r;
      out_size    = '0;
      out_addr    = miss_addr_r;
      out_data    = '0;
    end else if (state_r == e_send_uc_load) begin
      lce_req_v_o = md_v_r;
      out_msg     = e_req_uc_rd;
      out_size    = uc_size_r;
      out_addr    = miss_addr_r;
      out_data    = '0;
    end
  end

  assign lce_req_o = {out_addr[block_offset_lp +: cce_id_width_p], lce_id_i, out_msg,
                      1'b0, out_dirty, out_way, out_size, out_addr, out_data};
  assign uc_wr_xfer = lce_req_v_o & lce_req_ready_i & ~fifo_empty;
  assign miss_xfer  = lce_req_v_o & lce_req_ready_i & fifo_empty;

  assign lce_resp_v_o = (state_r == e_send_coh_ack);
  assign lce_resp_o   = {miss_addr_r[block_offset_lp +: cce_id_width_p], lce_id_i,
                         e_resp_coh_ack, miss_addr_r};

  assign timeout           = (timeout_cnt_r == timeout_limit_lp);
  assign cache_req_ready_o = cmd_ready_i & (state_r == e_ready) & ~timeout & ~fifo_full;
  assign fence_clear_o     = fifo_empty & (credits_r == credit_max_lp);
  assign miss_addr_o       = miss_addr_r;

  // Miss tracking, metadata capture, credits and timeout
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      miss_addr_r   <= '0;
      data_recv_r   <= 1'b0;
      tag_recv_r    <= 1'b0;
      md_v_r        <= 1'b0;
      credits_r     <= credit_max_lp;
      timeout_cnt_r <= '0;
    end else begin
      if (accept && (is_miss || req_msg == e_uc_load)) miss_addr_r <= req_addr;
      if (accept && is_miss) begin
        data_recv_r <= 1'b0;
        tag_recv_r  <= 1'b0;
      end else if (state_r == e_sleep) begin
        data_recv_r <= data_recv_r | cce_data_received_i;
        tag_recv_r  <= tag_recv_r | set_tag_received_i;
      end
      if (cache_req_metadata_v_i) md_v_r <= 1'b1;
      else if (accept)            md_v_r <= 1'b0;
      if (uc_wr_xfer && !uc_store_done_i)
        credits_r <= credits_r - credit_w_lp'(1);
      else if (!uc_wr_xfer && uc_store_done_i && credits_r != credit_max_lp)
        credits_r <= credits_r + credit_w_lp'(1);
      if (!coherence_blocked_i)           timeout_cnt_r <= '0;
      else if (timeout_cnt_r != timeout_limit_lp) timeout_cnt_r <= timeout_cnt_r + timeout_w_lp'(1);
    end
  end

  // Uncached-store FIFO control
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (fifo_enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (fifo_deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({fifo_enq, fifo_deq})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + fifo_cnt_w_lp'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - fifo_cnt_w_lp'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Datapath registers carry no reset
  always_ff @(posedge clk_i) begin
    if (accept && is_miss)                 load_not_store_r <= (req_msg == e_miss_load);
    if (accept && req_msg == e_uc_load)    uc_size_r <= req_size;
    if (cache_req_metadata_v_i) begin
      md_way_r   <= md_way;
      md_dirty_r <= md_dirty;
    end
    if (fifo_enq) fifo_mem[wr_ptr_r] <= {req_addr, req_size, req_data};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(uc_store_done_i && !uc_wr_xfer && credits_r == credit_max_lp))
        else $error("uc_store_done_i with all credits already returned");
      assert (!(state_r == e_ready && wake_any))
        else $error("wake pulse received while idle");
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_lce_req_buffered.sv
// Directed self-checking bench for bp_be_dcache_lce_req_buffered with default parameters.
module tb_bp_be_dcache_lce_req_buffered;

  localparam logic [2:0] MISS_LOAD = 3'd0, MISS_STORE = 3'd1, UC_LOAD = 3'd2, UC_STORE = 3'd3;
  localparam logic [2:0] REQ_RD = 3'd0, REQ_WR = 3'd1, REQ_UC_RD = 3'd2, REQ_UC_WR = 3'd3;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [3:0]   lce_id_i;
  logic [108:0] cache_req_i;
  logic         cache_req_v_i, cache_req_ready_o;
  logic [3:0]   cache_req_metadata_i;
  logic         cache_req_metadata_v_i;
  logic [39:0]  miss_addr_o;
  logic         coherence_blocked_i, cmd_ready_i;
  logic         cce_data_received_i, uncached_data_received_i;
  logic         set_tag_received_i, set_tag_wakeup_received_i;
  logic         uc_store_done_i, fence_clear_o;
  logic [121:0] lce_req_o;
  logic         lce_req_v_o, lce_req_ready_i;
  logic [50:0]  lce_resp_o;
  logic         lce_resp_v_o, lce_resp_yumi_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_lce_req_buffered dut (
    .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .cache_req_i(cache_req_i), .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
    .cache_req_metadata_i(cache_req_metadata_i), .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .miss_addr_o(miss_addr_o), .coherence_blocked_i(coherence_blocked_i), .cmd_ready_i(cmd_ready_i),
    .cce_data_received_i(cce_data_received_i), .uncached_data_received_i(uncached_data_received_i),
    .set_tag_received_i(set_tag_received_i), .set_tag_wakeup_received_i(set_tag_wakeup_received_i),
    .uc_store_done_i(uc_store_done_i), .fence_clear_o(fence_clear_o),
    .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i),
    .lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o), .lce_resp_yumi_i(lce_resp_yumi_i)
  );

  // Field views of the request/response links
  logic [63:0] rq_data;
  logic [39:0] rq_addr, rs_addr;
  logic [1:0]  rq_size;
  logic [2:0]  rq_way, rq_msg, rs_msg;
  logic        rq_dirty;
  logic [3:0]  rq_src, rq_dst, rs_src, rs_dst;
  assign rq_data  = lce_req_o[63:0];
  assign rq_addr  = lce_req_o[103:64];
  assign rq_size  = lce_req_o[105:104];
  assign rq_way   = lce_req_o[108:106];
  assign rq_dirty = lce_req_o[109];
  assign rq_msg   = lce_req_o[113:111];
  assign rq_src   = lce_req_o[117:114];
  assign rq_dst   = lce_req_o[121:118];
  assign rs_addr  = lce_resp_o[39:0];
  assign rs_msg   = lce_resp_o[42:40];
  assign rs_src   = lce_resp_o[46:43];
  assign rs_dst   = lce_resp_o[50:47];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic [2:0] msg, input logic [39:0] addr,
                         input logic [63:0] data);
    chk({tag, "_v"}, 128'(lce_req_v_o), 128'(1'b1));
    chk({tag, "_msg"}, 128'(rq_msg), 128'(msg));
    chk({tag, "_addr"}, 128'(rq_addr), 128'(addr));
    chk({tag, "_data"}, 128'(rq_data), 128'(data));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [2:0] msg, input logic [39:0] addr, input logic [1:0] size,
                           input logic [63:0] data);
    cache_req_i   = {msg, size, addr, data};
    cache_req_v_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; lce_id_i = 4'h5; cache_req_i = '0; cache_req_v_i = 1'b0;
    cache_req_metadata_i = '0; cache_req_metadata_v_i = 1'b0;
    coherence_blocked_i = 1'b0; cmd_ready_i = 1'b1;
    cce_data_received_i = 1'b0; uncached_data_received_i = 1'b0;
    set_tag_received_i = 1'b0; set_tag_wakeup_received_i = 1'b0;
    uc_store_done_i = 1'b0; lce_req_ready_i = 1'b0; lce_resp_yumi_i = 1'b0;
    tick(); tick(); settle();
    chk("rst_req_v", 128'(lce_req_v_o), 128'(0));
    chk("rst_resp_v", 128'(lce_resp_v_o), 128'(0));
    chk("rst_fence", 128'(fence_clear_o), 128'(1));
    chk("rst_miss_addr", 128'(miss_addr_o), 128'(0));
    reset_i = 1'b0;
    tick();

    // Cached store miss with metadata in the same cycle
    lce_req_ready_i = 1'b1;
    drive_req(MISS_STORE, 40'h80000040, 2'd3, 64'h0);
    cache_req_metadata_i = {3'd3, 1'b1}; cache_req_metadata_v_i = 1'b1;
    settle();
    chk("t1_ready", 128'(cache_req_ready_o), 128'(1));
    tick(); cache_req_v_i = 1'b0; cache_req_metadata_v_i = 1'b0; settle();
    chk_req("t1_req", REQ_WR, 40'h80000040, 64'h0);
    chk("t1_way", 128'(rq_way), 128'(3));
    chk("t1_dirty", 128'(rq_dirty), 128'(1));
    chk("t1_dst", 128'(rq_dst), 128'(1));
    chk("t1_src", 128'(rq_src), 128'(5));
    chk("t1_miss_addr", 128'(miss_addr_o), 128'(40'h80000040));
    chk("t1_busy", 128'(cache_req_ready_o), 128'(0));
    tick(); settle();
    chk("t1_sleep_v", 128'(lce_req_v_o), 128'(0));
    set_tag_received_i = 1'b1; tick(); set_tag_received_i = 1'b0; settle();
    chk("t1_tag_only", 128'(lce_resp_v_o), 128'(0));
    cce_data_received_i = 1'b1; tick(); cce_data_received_i = 1'b0; settle();
    chk("t1_ack_v", 128'(lce_resp_v_o), 128'(1));
    chk("t1_ack_msg", 128'(rs_msg), 128'(0));
    chk("t1_ack_addr", 128'(rs_addr), 128'(40'h80000040));
    chk("t1_ack_dst", 128'(rs_dst), 128'(1));
    chk("t1_ack_src", 128'(rs_src), 128'(5));
    tick(); settle();
    chk("t1_ack_hold", 128'(lce_resp_v_o), 128'(1));
    lce_resp_yumi_i = 1'b1; tick(); lce_resp_yumi_i = 1'b0; settle();
    chk("t1_ack_done", 128'(lce_resp_v_o), 128'(0));
    chk("t1_idle", 128'(cache_req_ready_o), 128'(1));

    // Unknown msg_type is ignored
    drive_req(3'd5, 40'h1234, 2'd0, 64'h0);
    tick(); cache_req_v_i = 1'b0; settle();
    chk("ign_ready", 128'(cache_req_ready_o), 128'(1));
    chk("ign_req_v", 128'(lce_req_v_o), 128'(0));
    chk("ign_fence", 128'(fence_clear_o), 128'(1));

    // FIFO back-pressure
    lce_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(UC_STORE, 40'h1000 + 40'(8 * i), 2'd3, 64'hA0 + 64'(i));
      settle();
      chk("t2_fill_ready", 128'(cache_req_ready_o), 128'(1));
      tick();
    end
    cache_req_v_i = 1'b0; settle();
    chk("t2_full", 128'(cache_req_ready_o), 128'(0));
    chk_req("t2_head", REQ_UC_WR, 40'h1000, 64'hA0);
    chk("t2_fence", 128'(fence_clear_o), 128'(0));
    lce_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_req("t2_drain", REQ_UC_WR, 40'h1000 + 40'(8 * i), 64'hA0 + 64'(i));
      tick();
    end
    settle();
    chk("t2_empty_v", 128'(lce_req_v_o), 128'(0));
    chk("t2_fence_wait", 128'(fence_clear_o), 128'(0));
    chk("t2_ready_back", 128'(cache_req_ready_o), 128'(1));
    uc_store_done_i = 1'b1; tick(); tick(); tick(); settle();
    chk("t2_fence_3", 128'(fence_clear_o), 128'(0));
    tick(); uc_store_done_i = 1'b0; settle();
    chk("t2_fence_4", 128'(fence_clear_o), 128'(1));

    // Credit exhaustion: ninth store waits for a credit
    for (int i = 0; i < 9; i++) begin
      drive_req(UC_STORE, 40'h2000 + 40'(8 * i), 2'd3, 64'(i));
      settle();
      chk("t3_ready", 128'(cache_req_ready_o), 128'(1));
      tick();
    end
    cache_req_v_i = 1'b0; settle();
    chk("t3_no_credit", 128'(lce_req_v_o), 128'(0));
    chk("t3_fence", 128'(fence_clear_o), 128'(0));
    tick(); settle();
    chk("t3_still_wait", 128'(lce_req_v_o), 128'(0));
    uc_store_done_i = 1'b1; settle();
    chk("t3_credit_pending", 128'(lce_req_v_o), 128'(0));
    tick(); uc_store_done_i = 1'b0; settle();
    chk_req("t3_ninth", REQ_UC_WR, 40'h2040, 64'h8);
    tick(); settle();
    chk("t3_sent", 128'(lce_req_v_o), 128'(0));
    uc_store_done_i = 1'b1;
    repeat (8) tick();
    uc_store_done_i = 1'b0; settle();
    chk("t3_fence_back", 128'(fence_clear_o), 128'(1));

    // Store/load ordering
    lce_req_ready_i = 1'b0;
    drive_req(UC_STORE, 40'h3000, 2'd3, 64'h11); tick();
    drive_req(UC_STORE, 40'h3008, 2'd3, 64'h22); tick();
    drive_req(UC_LOAD, 40'h4000, 2'd2, 64'h0);
    cache_req_metadata_i = {3'd0, 1'b0}; cache_req_metadata_v_i = 1'b1;
    settle();
    chk("t4_load_ready", 128'(cache_req_ready_o), 128'(1));
    tick(); cache_req_v_i = 1'b0; cache_req_metadata_v_i = 1'b0; settle();
    chk("t4_busy", 128'(cache_req_ready_o), 128'(0));
    chk_req("t4_first", REQ_UC_WR, 40'h3000, 64'h11);
    lce_req_ready_i = 1'b1;
    tick(); settle();
    chk_req("t4_second", REQ_UC_WR, 40'h3008, 64'h22);
    tick(); settle();
    chk_req("t4_load", REQ_UC_RD, 40'h4000, 64'h0);
    chk("t4_load_size", 128'(rq_size), 128'(2));
    chk("t4_miss_addr", 128'(miss_addr_o), 128'(40'h4000));
    tick(); settle();
    chk("t4_sleep_v", 128'(lce_req_v_o), 128'(0));
    uncached_data_received_i = 1'b1; tick(); uncached_data_received_i = 1'b0; settle();
    chk("t4_ready", 128'(cache_req_ready_o), 128'(1));
    chk("t4_no_ack", 128'(lce_resp_v_o), 128'(0));
    uc_store_done_i = 1'b1; tick(); tick(); uc_store_done_i = 1'b0; settle();
    chk("t4_fence", 128'(fence_clear_o), 128'(1));

    // Late metadata delays the cached request by two cycles
    drive_req(MISS_LOAD, 40'h80001080, 2'd3, 64'h0);
    settle();
    chk("t5_ready", 128'(cache_req_ready_o), 128'(1));
    tick(); cache_req_v_i = 1'b0; settle();
    chk("t5_wait1", 128'(lce_req_v_o), 128'(0));
    tick();
    cache_req_metadata_i = {3'd2, 1'b0}; cache_req_metadata_v_i = 1'b1; settle();
    chk("t5_wait2", 128'(lce_req_v_o), 128'(0));
    tick(); cache_req_metadata_v_i = 1'b0; settle();
    chk_req("t5_req", REQ_RD, 40'h80001080, 64'h0);
    chk("t5_way", 128'(rq_way), 128'(2));
    chk("t5_dirty", 128'(rq_dirty), 128'(0));
    chk("t5_dst", 128'(rq_dst), 128'(2));
    tick(); settle();
    chk("t5_sleep_v", 128'(lce_req_v_o), 128'(0));
    set_tag_wakeup_received_i = 1'b1; tick(); set_tag_wakeup_received_i = 1'b0; settle();
    chk("t5_ack_v", 128'(lce_resp_v_o), 128'(1));
    chk("t5_ack_addr", 128'(rs_addr), 128'(40'h80001080));
    lce_resp_yumi_i = 1'b1; tick(); lce_resp_yumi_i = 1'b0; settle();
    chk("t5_idle", 128'(cache_req_ready_o), 128'(1));

    // Coherence-blocked timeout
    coherence_blocked_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t6_ready", 128'(cache_req_ready_o), 128'(1));
      tick();
    end
    settle();
    chk("t6_timeout", 128'(cache_req_ready_o), 128'(0));
    coherence_blocked_i = 1'b0; settle();
    chk("t6_timeout_hold", 128'(cache_req_ready_o), 128'(0));
    tick(); settle();
    chk("t6_recover", 128'(cache_req_ready_o), 128'(1));

    // Reset mid-operation flushes the FIFO
    lce_req_ready_i = 1'b0;
    drive_req(UC_STORE, 40'h5000, 2'd3, 64'h55); tick();
    drive_req(UC_STORE, 40'h5008, 2'd3, 64'h66); tick();
    cache_req_v_i = 1'b0; settle();
    chk("t7_pending_v", 128'(lce_req_v_o), 128'(1));
    chk("t7_pending_fence", 128'(fence_clear_o), 128'(0));
    reset_i = 1'b1; settle();
    chk("t7_flush_v", 128'(lce_req_v_o), 128'(0));
    chk("t7_flush_fence", 128'(fence_clear_o), 128'(1));
    chk("t7_flush_addr", 128'(miss_addr_o), 128'(0));
    tick(); reset_i = 1'b0; tick(); settle();
    chk("t7_after_v", 128'(lce_req_v_o), 128'(0));
    chk("t7_after_ready", 128'(cache_req_ready_o), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
